// File: rtl/load_mem_ctrl_pkg.sv
// Shared constants for the load path: load_control encodings, fault causes,
// controller state type and request classification helper.
package load_mem_ctrl_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_NOP = 3'b111;

    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_BUSERR   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_FAULT
    } state_e;

    // Unused encodings behave exactly like LD_NOP.
    function automatic logic is_load(input logic [2:0] lc);
        case (lc)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: is_load = 1'b1;
            LD_NOP:                              is_load = 1'b0;
            default:                             is_load = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_data_align.sv
// Byte/half/word lane extraction with sign or zero extension, plus the
// alignment check for the same load_control/address pair.
module load_data_align
    import load_mem_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      load_control_i,
    input  logic [1:0]      ea_lo_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{ea_lo_i, 3'b000} +: 8];
    assign half_sel = ea_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = '0;
        case (load_control_i)
            LD_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            LD_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            LD_LW:   data_o = word_i;
            default: data_o = '0;
        endcase
    end

    always_comb begin
        misaligned_o = 1'b0;
        case (load_control_i)
            LD_LH, LD_LHU: misaligned_o = ea_lo_i[0];
            LD_LW:         misaligned_o = |ea_lo_i;
            default:       misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_mem_ctrl.sv
// Load-path sequencer: accepts one load, issues a single memory read and
// returns the extended result or a fault (misaligned, bus error, timeout).
module load_mem_ctrl
    import load_mem_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      load_control,
    input  logic [XLEN-1:0] base,
    input  logic [11:0]     imm,
    input  logic [4:0]      rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault_valid,
    output logic [1:0]      fault_cause,
    output logic [XLEN-1:0] fault_addr
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e          state_q, state_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [2:0]      lc_q, lc_d;
    logic [4:0]      rd_q, rd_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [1:0]      fc_q, fc_d;
    logic [XLEN-1:0] fa_q, fa_d;

    logic [XLEN-1:0] ea_new;
    logic [7:0]      cnt_inc;
    logic [2:0]      align_lc;
    logic [1:0]      align_lo;
    logic [XLEN-1:0] align_data;
    logic            align_mis;

    assign ea_new  = base + {{(XLEN-12){imm[11]}}, imm};
    assign cnt_inc = cnt_q + 8'd1;

    // One aligner serves both paths: in IDLE it checks the incoming request,
    // elsewhere it extracts from the response using the captured load.
    assign align_lc = (state_q == S_IDLE) ? load_control : lc_q;
    assign align_lo = (state_q == S_IDLE) ? ea_new[1:0] : ea_q[1:0];

    load_data_align #(.XLEN(XLEN)) u_align (
        .load_control_i (align_lc),
        .ea_lo_i        (align_lo),
        .word_i         (mem_rsp_data),
        .data_o         (align_data),
        .misaligned_o   (align_mis)
    );

    always_comb begin
        state_d   = state_q;
        ea_d      = ea_q;
        lc_d      = lc_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        fc_d      = fc_q;
        fa_d      = fa_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ea_d = ea_new;
                    lc_d = load_control;
                    rd_d = rd;
                    if (is_load(load_control)) begin
                        if (align_mis) begin
                            state_d = S_FAULT;
                            fc_d    = FLT_MISALIGN;
                            fa_d    = ea_new;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        state_d = S_FAULT;
                        fc_d    = FLT_BUSERR;
                        fa_d    = ea_q;
                    end else begin
                        state_d   = S_WB;
                        wb_data_d = align_data;
                        wb_rd_d   = rd_q;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIMIT) begin
                        state_d = S_FAULT;
                        fc_d    = FLT_TIMEOUT;
                        fa_d    = ea_q;
                    end
                end
            end
            S_WB:    state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ea_q      <= '0;
            lc_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            fc_q      <= '0;
            fa_q      <= '0;
        end else begin
            state_q   <= state_d;
            ea_q      <= ea_d;
            lc_q      <= lc_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            fc_q      <= fc_d;
            fa_q      <= fa_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {ea_q[XLEN-1:2], 2'b00};
    assign wb_valid      = (state_q == S_WB) && (rd_q != 5'd0);
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign fault_valid   = (state_q == S_FAULT);
    assign fault_cause   = fc_q;
    assign fault_addr    = fa_q;

endmodule

// File: doc/load_mem_ctrl.md
# load_mem_ctrl

Sequencing controller for the load path. It takes one decoded load at a time: a load_control code, base register value, 12-bit immediate and destination register. It computes the effective address and checks alignment, then runs a valid/ready request and response transaction on the data-memory port. Finally it extracts and extends the addressed byte, half or word and presents it for register-file writeback. It sits between decode/execute and the data-memory interface and stalls the front end through req_ready while a load is in flight.

## Interface
Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a timeout fault is raised (1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a load request is presented.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- load_control  in  3  `LB/`LH/`LW/`LBU/`LHU/`LD_NOP.
- base  in  XLEN  rs1 value.
- imm  in  12  signed offset.
- rd  in  5  destination register.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  XLEN  word-aligned address ({ea[31:2],2'b00}).
- mem_rsp_valid  in  1  read data is valid.
- mem_rsp_data  in  XLEN  full word read.
- mem_rsp_err  in  1  bus error accompanying the response.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  XLEN  extended load result.
- fault_valid  out  1  one-cycle fault strobe.
- fault_cause  out  2  1 = misaligned, 2 = bus error, 3 = timeout.
- fault_addr  out  XLEN  effective address of the faulting load.

## Operation
- Effective address: ea = base + sign-extended imm, modulo 2^32 (wraps silently).
- Acceptance: a request is accepted on req_valid && req_ready. On acceptance, ea, load_control and rd are registered.
- States: IDLE, REQ, WAIT, WB, FAULT.
- Transitions out of IDLE on acceptance:
  - `LD_NOP: stays in IDLE. No memory access, no wb, no fault.
  - Misaligned access: goes to FAULT. Misaligned means LH/LHU with ea[0]=1, or LW with ea[1:0]≠0. No memory access is made.
  - Otherwise: goes to REQ.
- REQ: mem_req_valid=1, with mem_addr held stable until mem_req_ready, then WAIT. The timeout counter is cleared on entry to WAIT.
- WAIT: on mem_rsp_valid, the response is captured.
  - With mem_rsp_err=1: goes to FAULT with cause 2.
  - Otherwise: goes to WB.
  - The counter increments each WAIT cycle without a response. At count == TIMEOUT_CYCLES the controller goes to FAULT with cause 3.
  - A response in the same cycle the limit is reached takes priority over the timeout.
- WB: wb_valid=1 for one cycle, then IDLE. wb_valid is suppressed when rd == 0, but the state still advances.
- FAULT: fault_valid=1 for one cycle with cause and ea, then IDLE.
- Data extraction:
  - Byte lane = ea[1:0]; half lane = ea[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Any mem_rsp_valid in IDLE, REQ, WB or FAULT is ignored. This covers stale responses after a timeout or reset.
- Unknown load_control encodings are treated as `LD_NOP.

## Timing
- Reset (asynchronous): state=IDLE and counter=0. All outputs are 0 except req_ready=1; wb_rd, wb_data, fault_cause, fault_addr and mem_addr are all 0.
- Reset mid-transaction abandons the load with no wb and no fault.
- Minimum load latency, with acceptance at edge T and mem_req_ready held high:
  - mem_req_valid in cycle T+1.
  - Response accepted in cycle T+2.
  - wb_valid in cycle T+3.
  - req_ready again in cycle T+4.
- Misaligned load: fault_valid in T+1, req_ready in T+2.
- `LD_NOP: req_ready stays high, so back-to-back acceptance is allowed.
- All outputs are registered from state.
- wb_data, wb_rd, fault_cause and fault_addr are valid only while their strobe is high. They hold their last value otherwise.

## Structure
- processor_defines.sv holds the shared constants:
  - The load_control encodings (`LB, `LH, `LW, `LBU, `LHU, `LD_NOP).
  - The fault-cause constants FLT_MISALIGN=2'd1, FLT_BUSERR=2'd2, FLT_TIMEOUT=2'd3.
  - The FSM state enum type.
- One combinational sub-module, load_data_align, takes (load_control, ea[1:0], word) and produces the extended result. The same sub-module provides the misalignment check.
- The top level holds the FSM, registers and timeout counter.

## Test plan
- LW, base=0x1000, imm=0x004, rd=5, memory returns 0xDEADBEEF with zero wait states -> mem_addr=0x1004; wb_valid at T+3 with wb_rd=5, wb_data=0xDEADBEEF.
- LB and LBU at ea=0x2003, word 0x80FF_FF7F:
  - LB -> wb_data=0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH at ea=0x2002 -> 0xFFFF80FF.
- LH at ea=0x3001 -> fault_valid at T+1, cause=1, fault_addr=0x3001; mem_req_valid never asserted.
- Memory holds mem_req_ready low for 3 cycles and then returns mem_rsp_err=1 -> mem_addr stable throughout; fault cause=2; no wb_valid.
- No response with TIMEOUT_CYCLES=4 -> fault cause=3 after 4 WAIT cycles. A late mem_rsp_valid arriving in IDLE is ignored.
- rst asserted during WAIT -> outputs return to reset values immediately with no wb or fault. A new LW is then accepted and completes normally. Also: imm=0xFFF with base=0 -> ea=0xFFFFFFFF wraps, and the LBU completes.
